// File: rtl/seq_controller_pkg.sv
// Shared types and constants for the two-memory sequencer: state encodings, default phase lengths, length check.
// Latency: none (package only).
// Backpressure: not applicable.
package seq_controller_pkg;

    // State encodings; the same 3-bit values are exported on the phase port
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_SCAN = 3'd2,
        ST_XWR  = 3'd3,
        ST_XINC = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    localparam int DEF_FILL_LEN = 8;
    localparam int DEF_SCAN_LEN = 2;
    localparam int DEF_XFER_LEN = 4;
    localparam int DEF_CNT_W    = 8;

    // A phase length must be at least 1 and must fit the counter after the -1 preload
    function automatic bit len_ok(input int len, input int cnt_w);
        longint max_len;
        max_len = (longint'(1) << cnt_w) - 1;
        return (len >= 1) && (longint'(len) <= max_len);
    endfunction

endpackage

// File: rtl/seq_phase_cnt.sv
// Loadable down counter that times each sequencer phase; zero flag ends the phase.
// Latency: load/dec/clear take effect on the next clock edge; zero is decoded from the registered count.
// Backpressure: none; the controller drives it every cycle.
module seq_phase_cnt
#(
    parameter int CNT_W = 8
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic             clear,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins over load, load wins over decrement
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (dec) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register, cleared by the asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/seq_controller.sv
// Sequencer: fill A, scan A, alternate B write/increment, then a one-cycle done pulse. Optional macro SEQ_CONTROLLER_AUTO_RESTART_EN.
// Latency: start sampled in IDLE at edge k puts FILL strobes out after edge k; all outputs are registered Moore decodes.
// Backpressure: none; start is ignored while busy (no queuing), abort forces IDLE on the next edge.
module seq_controller
    import seq_controller_pkg::*;
#(
    parameter int FILL_LEN = DEF_FILL_LEN,
    parameter int SCAN_LEN = DEF_SCAN_LEN,
    parameter int XFER_LEN = DEF_XFER_LEN,
    parameter int CNT_W    = DEF_CNT_W
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    output logic       wea,
    output logic       inca,
    output logic       web,
    output logic       incb,
    output logic       busy,
    output logic       done,
    output logic [2:0] phase
);

    // Reject zero or oversized phase lengths when the design is elaborated
    if (!len_ok(FILL_LEN, CNT_W)) begin : g_bad_fill_len
        $error("seq_controller: FILL_LEN out of range for CNT_W");
    end
    if (!len_ok(SCAN_LEN, CNT_W)) begin : g_bad_scan_len
        $error("seq_controller: SCAN_LEN out of range for CNT_W");
    end
    if (!len_ok(XFER_LEN, CNT_W)) begin : g_bad_xfer_len
        $error("seq_controller: XFER_LEN out of range for CNT_W");
    end

    // Counter preloads are length-1 so the phase ends on the cycle the counter reads zero
    localparam logic [CNT_W-1:0] FILL_LD = CNT_W'(FILL_LEN - 1);
    localparam logic [CNT_W-1:0] SCAN_LD = CNT_W'(SCAN_LEN - 1);
    localparam logic [CNT_W-1:0] XFER_LD = CNT_W'(XFER_LEN - 1);

    state_e           state_q, state_d;
    logic             wea_q, wea_d;
    logic             inca_q, inca_d;
    logic             web_q, web_d;
    logic             incb_q, incb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cnt_load, cnt_dec, cnt_clr, cnt_zero;
    logic [CNT_W-1:0] cnt_ld_val;

    seq_phase_cnt #(
        .CNT_W    (CNT_W)
    ) u_phase_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .clear    (cnt_clr),
        .load_val (cnt_ld_val),
        .zero     (cnt_zero)
    );

    // Next state and counter control; abort overrides every transition
    always_comb begin
        state_d    = state_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_ld_val = '0;
        if (abort) begin
            state_d = ST_IDLE;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d    = ST_FILL;
                        cnt_load   = 1'b1;
                        cnt_ld_val = FILL_LD;
                    end
                end
                ST_FILL: begin
                    if (cnt_zero) begin
                        state_d    = ST_SCAN;
                        cnt_load   = 1'b1;
                        cnt_ld_val = SCAN_LD;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (cnt_zero) begin
                        state_d    = ST_XWR;
                        cnt_load   = 1'b1;
                        cnt_ld_val = XFER_LD;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ST_XWR: begin
                    state_d = ST_XINC;
                end
                ST_XINC: begin
                    if (cnt_zero) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_XWR;
                        cnt_dec = 1'b1;
                    end
                end
                ST_DONE: begin
`ifdef SEQ_CONTROLLER_AUTO_RESTART_EN
                    state_d    = ST_FILL;
                    cnt_load   = 1'b1;
                    cnt_ld_val = FILL_LD;
`else
                    state_d    = ST_IDLE;
`endif
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

    // Decode strobes from the next state so the registered outputs line up with state_q
    always_comb begin
        wea_d  = (state_d == ST_FILL);
        inca_d = (state_d == ST_FILL) || (state_d == ST_SCAN);
        web_d  = (state_d == ST_XWR);
        incb_d = (state_d == ST_XINC);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State register and registered Moore outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            wea_q   <= 1'b0;
            inca_q  <= 1'b0;
            web_q   <= 1'b0;
            incb_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wea_q   <= wea_d;
            inca_q  <= inca_d;
            web_q   <= web_d;
            incb_q  <= incb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign wea   = wea_q;
    assign inca  = inca_q;
    assign web   = web_q;
    assign incb  = incb_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign phase = state_q;

endmodule

// File: tb/tb_seq_controller.sv
// Bench for seq_controller: default-length instance plus a 1/1/1 instance, directed cycle tables.
// Cycle n means the interval after the n-th clock edge counted from the start of each test.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_seq_controller;

`ifdef SEQ_CONTROLLER_AUTO_RESTART_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    // Packed observation order: {wea, inca, web, incb, busy, done, phase[2:0]}
    localparam logic [8:0] V_IDLE = 9'b000000000;
    localparam logic [8:0] V_FILL = 9'b110010001;

    logic clk = 1'b0;
    logic reset;
    logic start_a, abort_a, start_b, abort_b;
    logic wea_a, inca_a, web_a, incb_a, busy_a, done_a;
    logic wea_b, inca_b, web_b, incb_b, busy_b, done_b;
    logic [2:0] phase_a, phase_b;
    logic [8:0] obs_a, obs_b;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       start;
        logic       abort;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl [0:27];

    always #5 clk = ~clk;

    seq_controller #(
        .FILL_LEN (8),
        .SCAN_LEN (2),
        .XFER_LEN (4),
        .CNT_W    (8)
    ) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .start (start_a),
        .abort (abort_a),
        .wea   (wea_a),
        .inca  (inca_a),
        .web   (web_a),
        .incb  (incb_a),
        .busy  (busy_a),
        .done  (done_a),
        .phase (phase_a)
    );

    seq_controller #(
        .FILL_LEN (1),
        .SCAN_LEN (1),
        .XFER_LEN (1),
        .CNT_W    (8)
    ) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .start (start_b),
        .abort (abort_b),
        .wea   (wea_b),
        .inca  (inca_b),
        .web   (web_b),
        .incb  (incb_b),
        .busy  (busy_b),
        .done  (done_b),
        .phase (phase_b)
    );

    assign obs_a = {wea_a, inca_a, web_a, incb_a, busy_a, done_a, phase_a};
    assign obs_b = {wea_b, inca_b, web_b, incb_b, busy_b, done_b, phase_b};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b (wea,inca,web,incb,busy,done,phase)", name, act, exp);
        end
    endtask

    // One-cycle abort to bring an instance back to IDLE between tests
    task automatic abort_a_idle(input string name);
        start_a = 1'b0;
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        check(name, obs_a, V_IDLE);
    endtask

    initial begin
        // Expected default run, cycle by cycle, from the documented timing
        for (int c = 0; c <= 27; c++) begin
            logic w, ia, wb, ib, bz, dn;
            logic [2:0] ph;
            logic rst_run;
            rst_run = AUTO && (c >= 20) && (c <= 27);
            w  = ((c >= 1) && (c <= 8)) || rst_run;
            ia = ((c >= 1) && (c <= 10)) || rst_run;
            wb = (c == 11) || (c == 13) || (c == 15) || (c == 17);
            ib = (c == 12) || (c == 14) || (c == 16) || (c == 18);
            dn = (c == 19);
            bz = ((c >= 1) && (c <= 19)) || rst_run;
            if ((c >= 1) && (c <= 8)) ph = 3'd1;
            else if ((c >= 9) && (c <= 10)) ph = 3'd2;
            else if (wb) ph = 3'd3;
            else if (ib) ph = 3'd4;
            else if (dn) ph = 3'd5;
            else if (rst_run) ph = 3'd1;
            else ph = 3'd0;
            tbl[c].start = (c == 0);
            tbl[c].abort = 1'b0;
            tbl[c].exp   = {w, ia, wb, ib, bz, dn, ph};
        end

        reset   = 1'b0;
        start_a = 1'b0;
        abort_a = 1'b0;
        start_b = 1'b0;
        abort_b = 1'b0;

        // Reset state
        step();
        step();
        check("reset_a", obs_a, V_IDLE);
        check("reset_b", obs_b, V_IDLE);
        reset = 1'b1;
        step();
        check("post_reset_a", obs_a, V_IDLE);

        // Default sequence driven from the table
        for (int c = 0; c <= 27; c++) begin
            check($sformatf("dflt_c%0d", c), obs_a, tbl[c].exp);
            start_a = tbl[c].start;
            abort_a = tbl[c].abort;
            step();
        end
        abort_a_idle("dflt_to_idle");

        // Abort during FILL cycle 5: strobes drop from cycle 6, no done
        for (int c = 0; c <= 12; c++) begin
            logic [8:0] e;
            e = ((c >= 1) && (c <= 5)) ? V_FILL : V_IDLE;
            check($sformatf("abort_c%0d", c), obs_a, e);
            start_a = (c == 0);
            abort_a = (c == 5);
            step();
        end
        abort_a = 1'b0;

        // start held high: ignored while busy, next FILL after the idle gap
        for (int c = 0; c <= 22; c++) begin
            logic [8:0] e;
            if (c <= 19) e = tbl[c].exp;
            else if (c == 20) e = AUTO ? V_FILL : V_IDLE;
            else e = V_FILL;
            check($sformatf("hold_c%0d", c), obs_a, e);
            start_a = 1'b1;
            step();
        end
        abort_a_idle("hold_to_idle");

        // Minimum lengths 1/1/1
        begin
            logic [8:0] exp_b [0:6];
            exp_b[0] = V_IDLE;
            exp_b[1] = 9'b110010001;
            exp_b[2] = 9'b010010010;
            exp_b[3] = 9'b001010011;
            exp_b[4] = 9'b000110100;
            exp_b[5] = 9'b000011101;
            exp_b[6] = AUTO ? V_FILL : V_IDLE;
            for (int c = 0; c <= 6; c++) begin
                check($sformatf("min_c%0d", c), obs_b, exp_b[c]);
                start_b = (c == 0);
                step();
            end
            abort_b = 1'b1;
            step();
            abort_b = 1'b0;
            check("min_to_idle", obs_b, V_IDLE);
        end

        // abort and start together in IDLE: stays IDLE
        start_a = 1'b1;
        abort_a = 1'b1;
        step();
        check("abort_start_idle", obs_a, V_IDLE);
        start_a = 1'b0;
        abort_a = 1'b0;

        // Asynchronous reset in the middle of the transfer phase
        for (int c = 0; c < 12; c++) begin
            start_a = (c == 0);
            step();
        end
        check("pre_reset_xinc", obs_a, tbl[12].exp);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_a", obs_a, V_IDLE);
        step();
        reset = 1'b1;
        step();
        check("after_reset_idle", obs_a, V_IDLE);
        step();
        check("after_reset_idle2", obs_a, V_IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
